// File: rtl/config_reg_bank_pkg.sv
// rtl/config_reg_bank_pkg.sv - shared constants and register indices for the configuration register bank
package config_reg_bank_pkg;

  localparam logic [31:0] DEFAULT_RST_VALUES = 32'h2081_0000;
  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 2;

  typedef enum int {
    REG_ALU_OPERAND_A = 0,
    REG_ALU_OPERAND_B = 1,
    REG_UART_CONFIG   = 2,
    REG_CLK_DIV_RATIO = 3
  } reg_idx_e;

  function automatic bit rd_latency_legal(input int lat);
    return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/config_reg_bank_rd_data_pipe.sv
// rtl/config_reg_bank_rd_data_pipe.sv - fixed-depth read data/valid/err delay line with synchronous clear
module rd_data_pipe #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in_err,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic             out_err,
  output logic [WIDTH-1:0] out_data
);

  logic [LATENCY-1:0]            valid_q, valid_d;
  logic [LATENCY-1:0]            err_q, err_d;
  logic [LATENCY-1:0][WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d    = valid_q;
    err_d      = err_q;
    data_d     = data_q;
    valid_d[0] = in_valid;
    err_d[0]   = in_err;
    data_d[0]  = in_data;
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      err_d[i]   = err_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= '0;
      err_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_err   = err_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/config_reg_bank.sv
// rtl/config_reg_bank.sv - parameterised configuration register bank with exported low registers
module config_reg_bank
  import config_reg_bank_pkg::*;
#(
  parameter int                              REG_WIDTH  = 8,
  parameter int                              DEPTH      = 16,
  parameter int                              ADDR_WIDTH = 4,
  parameter int                              NUM_EXPORT = 4,
  parameter logic [NUM_EXPORT*REG_WIDTH-1:0] RST_VALUES = DEFAULT_RST_VALUES,
  parameter int                              RD_LATENCY = 1
) (
  input  logic                            i_CLK,
  input  logic                            i_RST,
  input  logic                            i_WrEn,
  input  logic                            i_RdEn,
  input  logic [ADDR_WIDTH-1:0]           i_Address,
  input  logic [REG_WIDTH-1:0]            i_WrData,
  output logic [REG_WIDTH-1:0]            o_RdData,
  output logic                            o_RdData_Valid,
  output logic                            o_Err,
  output logic [NUM_EXPORT*REG_WIDTH-1:0] o_Export,
  output logic [NUM_EXPORT-1:0]           o_Export_Upd
);

  if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
    $error("config_reg_bank: RD_LATENCY must be 1 or 2");
  end
  if (NUM_EXPORT > DEPTH) begin : g_bad_export
    $error("config_reg_bank: NUM_EXPORT exceeds DEPTH");
  end
  if ((2 ** ADDR_WIDTH) < DEPTH) begin : g_bad_addr
    $error("config_reg_bank: ADDR_WIDTH too narrow for DEPTH");
  end

  // Registers above the exported window reset to zero.
  localparam logic [DEPTH*REG_WIDTH-1:0] RST_IMAGE = (DEPTH*REG_WIDTH)'(RST_VALUES);

  logic [DEPTH-1:0][REG_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_EXPORT-1:0]           upd_q, upd_d;
  logic                            wr_err_q, wr_err_d;
  logic                            in_range, wr_ok;
  logic                            pipe_valid_in, pipe_err_in, pipe_err_out;
  logic [REG_WIDTH-1:0]            pipe_data_in;

  assign in_range = int'(i_Address) < DEPTH;
  assign wr_ok    = i_WrEn && in_range;

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[i_Address] = i_WrData;
    for (int k = 0; k < NUM_EXPORT; k++) upd_d[k] = wr_ok && (int'(i_Address) == k);
    wr_err_d = i_WrEn && !in_range;
  end

  // A read colliding with a write is dropped but still reports an error at read latency.
  always_comb begin
    pipe_valid_in = i_RdEn && !i_WrEn;
    pipe_err_in   = i_RdEn && (i_WrEn || !in_range);
    pipe_data_in  = (pipe_valid_in && in_range) ? regs_q[i_Address] : '0;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      regs_q   <= RST_IMAGE;
      upd_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      upd_q    <= upd_d;
      wr_err_q <= wr_err_d;
    end
  end

  rd_data_pipe #(
    .WIDTH   (REG_WIDTH),
    .LATENCY (RD_LATENCY)
  ) u_rd_data_pipe (
    .clk       (i_CLK),
    .clr       (i_RST),
    .in_valid  (pipe_valid_in),
    .in_err    (pipe_err_in),
    .in_data   (pipe_data_in),
    .out_valid (o_RdData_Valid),
    .out_err   (pipe_err_out),
    .out_data  (o_RdData)
  );

  assign o_Err        = pipe_err_out | wr_err_q;
  assign o_Export     = regs_q[NUM_EXPORT-1:0];
  assign o_Export_Upd = upd_q;

endmodule

// File: tb/tb_config_reg_bank.sv
// tb/tb_config_reg_bank.sv - self-checking bench for config_reg_bank
module tb_config_reg_bank;
  import config_reg_bank_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 12;
  localparam int AW    = 4;
  localparam int NEXP  = 4;
  localparam int LAT   = 2;

  logic             clk = 1'b0;
  logic             rst, wr, rd;
  logic [AW-1:0]    addr;
  logic [W-1:0]     wdata;
  logic [W-1:0]     rd_data;
  logic             rd_valid, err;
  logic [NEXP*W-1:0] export_bus;
  logic [NEXP-1:0]  export_upd;

  always #5 clk = ~clk;

  config_reg_bank #(
    .REG_WIDTH  (W),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .NUM_EXPORT (NEXP),
    .RST_VALUES (32'h2081_0000),
    .RD_LATENCY (LAT)
  ) dut (
    .i_CLK          (clk),
    .i_RST          (rst),
    .i_WrEn         (wr),
    .i_RdEn         (rd),
    .i_Address      (addr),
    .i_WrData       (wdata),
    .o_RdData       (rd_data),
    .o_RdData_Valid (rd_valid),
    .o_Err          (err),
    .o_Export       (export_bus),
    .o_Export_Upd   (export_upd)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: register contents plus a time-indexed schedule of expected read/err outputs.
  logic [W-1:0]    m_regs [DEPTH];
  bit              m_v [16];
  bit              m_e [16];
  logic [W-1:0]    m_d [16];
  logic [NEXP-1:0] m_upd;
  int              cyc = 0;
  bit              m_live = 0;

  always @(posedge clk) begin
    int slot;
    cyc++;
    m_upd = '0;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
      m_regs[2] = 8'h81;
      m_regs[3] = 8'h20;
      for (int j = 0; j < LAT; j++) begin
        m_v[(cyc + j) % 16] = 1'b0;
        m_e[(cyc + j) % 16] = 1'b0;
        m_d[(cyc + j) % 16] = '0;
      end
      m_live = 1'b1;
    end else if (m_live) begin
      slot = (cyc + LAT - 1) % 16;
      if (rd) begin
        if (wr) m_e[slot] = 1'b1;
        else begin
          m_v[slot] = 1'b1;
          m_e[slot] = (addr >= DEPTH);
          m_d[slot] = (addr < DEPTH) ? m_regs[addr] : '0;
        end
      end
      if (wr) begin
        if (addr < DEPTH) begin
          m_regs[addr] = wdata;
          if (addr < NEXP) m_upd[addr] = 1'b1;
        end else begin
          m_e[cyc % 16] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    int s;
    if (m_live) begin
      s = cyc % 16;
      check("cmp_valid", 32'(rd_valid), 32'(m_v[s]));
      check("cmp_data", 32'(rd_data), 32'(m_d[s]));
      check("cmp_err", 32'(err), 32'(m_e[s]));
      check("cmp_export", export_bus, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
      check("cmp_upd", 32'(export_upd), 32'(m_upd));
      m_v[s] = 1'b0;
      m_e[s] = 1'b0;
      m_d[s] = '0;
    end
  end

  typedef struct {
    bit         w;
    bit         r;
    logic [3:0] a;
    logic [7:0] d;
  } op_t;

  op_t ops [8] = '{
    '{1'b1, 1'b0, 4'd8,  8'h5A},
    '{1'b0, 1'b1, 4'd8,  8'h00},
    '{1'b1, 1'b0, 4'd3,  8'hC3},
    '{1'b0, 1'b1, 4'd3,  8'h00},
    '{1'b0, 1'b1, 4'd11, 8'h00},
    '{1'b1, 1'b1, 4'd15, 8'h77},
    '{1'b0, 1'b1, 4'd12, 8'h00},
    '{1'b1, 1'b0, 4'd2,  8'h81}
  };

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_export", export_bus, 32'h2081_0000);
    check("reset_valid", 32'(rd_valid), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_upd", 32'(export_upd), 32'd0);

    // Back-to-back reads of regs 2, 3, 5.
    rd = 1'b1; addr = AW'(REG_UART_CONFIG);
    tick();
    check("rd_not_early", 32'(rd_valid), 32'd0);
    addr = AW'(REG_CLK_DIV_RATIO);
    tick();
    check("rd2_data", 32'(rd_data), 32'h81);
    check("rd2_valid", 32'(rd_valid), 32'd1);
    addr = 4'd5;
    tick();
    rd = 1'b0;
    check("rd3_data", 32'(rd_data), 32'h20);
    check("rd3_valid", 32'(rd_valid), 32'd1);
    tick();
    check("rd5_data", 32'(rd_data), 32'h00);
    check("rd5_valid", 32'(rd_valid), 32'd1);
    tick();
    check("rd_idle_valid", 32'(rd_valid), 32'd0);

    // Write A5 to reg 1.
    wr = 1'b1; addr = AW'(REG_ALU_OPERAND_B); wdata = 8'hA5;
    tick();
    wr = 1'b0;
    check("wr1_export", 32'(export_bus[15:8]), 32'hA5);
    check("wr1_upd", 32'(export_upd), 32'b0010);
    tick();
    check("wr1_upd_drop", 32'(export_upd), 32'd0);

    // Same-value write still pulses its update bit.
    wr = 1'b1; addr = AW'(REG_ALU_OPERAND_A); wdata = 8'h00;
    tick();
    wr = 1'b0;
    check("wr0_same_upd", 32'(export_upd), 32'b0001);

    // In-flight read data unaffected by a following write.
    wr = 1'b1; addr = 4'd7; wdata = 8'h11;
    tick();
    wr = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0; wr = 1'b1; wdata = 8'h22;
    tick();
    wr = 1'b0;
    check("inflight_data", 32'(rd_data), 32'h11);
    check("inflight_valid", 32'(rd_valid), 32'd1);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tick();
    check("reg7_new", 32'(rd_data), 32'h22);

    // Out-of-range write then read.
    wr = 1'b1; addr = 4'd13; wdata = 8'hFF;
    tick();
    wr = 1'b0;
    check("oor_wr_err", 32'(err), 32'd1);
    check("oor_wr_export", export_bus, 32'h2081_A500);
    check("oor_wr_upd", 32'(export_upd), 32'd0);
    tick();
    check("oor_wr_err_drop", 32'(err), 32'd0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tick();
    check("oor_rd_data", 32'(rd_data), 32'h00);
    check("oor_rd_valid", 32'(rd_valid), 32'd1);
    check("oor_rd_err", 32'(err), 32'd1);

    // Simultaneous write and read.
    wr = 1'b1; rd = 1'b1; addr = 4'd4; wdata = 8'h3C;
    tick();
    wr = 1'b0; rd = 1'b0;
    check("wrrd_err_early", 32'(err), 32'd0);
    tick();
    check("wrrd_err", 32'(err), 32'd1);
    check("wrrd_no_valid", 32'(rd_valid), 32'd0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tick();
    check("reg4_value", 32'(rd_data), 32'h3C);

    // Reset with a read in flight.
    rd = 1'b1; addr = 4'd2;
    tick();
    rd = 1'b0; rst = 1'b1;
    tick();
    check("rst_inflight_valid", 32'(rd_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_valid", 32'(rd_valid), 32'd0);
    end
    check("post_rst_export", export_bus, 32'h2081_0000);

    // Mixed traffic checked by the model.
    for (int i = 0; i < 8; i++) begin
      wr = ops[i].w; rd = ops[i].r; addr = ops[i].a; wdata = ops[i].d;
      tick();
    end
    wr = 1'b0; rd = 1'b0;
    tick();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
